// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//   Walks register-file addresses FIRST_REG..LAST_REG through a spare
//   combinational read port and streams {addr, data} pairs over a
//   valid/ready interface, then pulses done for one cycle.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   defined   -> dump_csum is a running sum of the captured words
//   undefined -> dump_csum is tied to 0 and no adder is built
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a dump (sampled only in IDLE)
//   abort          synchronous cancel of a dump in progress
//   rf_readreg     spare read-port address (always equals the pointer)
//   rf_readdata    combinational read data for rf_readreg
//   dump_valid/dump_ready/dump_addr/dump_data   output word stream
//   dump_csum      running checksum
//   busy           high in READ and DRAIN
//   done           one-cycle pulse after the last word transfers
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_readreg,
    input  logic [DATA_W-1:0] rf_readdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [DATA_W-1:0] dump_csum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic active;   // READ or DRAIN: the states abort applies to
    logic capture;  // load a new word into the output register
    logic at_last;
    logic xfer;

    assign active  = (state_q == S_READ) || (state_q == S_DRAIN);
    // abort wins over a capture in the same cycle
    assign capture = (state_q == S_READ) && (!valid_q || dump_ready) && !abort;
    assign at_last = (ptr_q == LAST_A);
    assign xfer    = valid_q && dump_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ: begin
                if (abort)                   state_d = S_IDLE;
                else if (capture && at_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)     state_d = S_IDLE;
                else if (xfer) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_READ, S_DRAIN: busy = 1'b1;
            S_DONE:          done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= FIRST_A;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (active && abort) begin
            valid_q <= 1'b0;
            ptr_q   <= FIRST_A;
        end else if (capture) begin
            data_q  <= rf_readdata;
            addr_q  <= ptr_q;
            valid_q <= 1'b1;
            // pointer parks on LAST_REG; it is rewound on DONE or abort
            if (!at_last) ptr_q <= ptr_q + 1'b1;
        end else if (state_q == S_DRAIN && xfer) begin
            valid_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            ptr_q <= FIRST_A;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             csum_q <= '0;
        else if (state_q == S_IDLE && start) csum_q <= '0;
        else if (capture)                    csum_q <= csum_q + rf_readdata;
    end

    assign dump_csum = csum_q;
`else
    assign dump_csum = '0;
`endif

    assign rf_readreg = ptr_q;
    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, dump_ready = 1'b1;
    logic [4:0]  rf_readreg, dump_addr;
    logic [31:0] rf_readdata, dump_data, dump_csum;
    logic        dump_valid, busy, done;

    // second instance: single-register dump of r30
    logic        start1 = 1'b0;
    logic [4:0]  rf_readreg1, dump_addr1;
    logic [31:0] rf_readdata1, dump_data1, dump_csum1;
    logic        dump_valid1, busy1, done1;

    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } word_t;
    word_t exp_q [$];

    always #5 clk = ~clk;

    assign rf_readdata  = rf[rf_readreg];
    assign rf_readdata1 = rf[rf_readreg1];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_readreg(rf_readreg), .rf_readdata(rf_readdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_csum(dump_csum),
        .busy(busy), .done(done));

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(30), .LAST_REG(30)) u_one (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .rf_readreg(rf_readreg1), .rf_readdata(rf_readdata1),
        .dump_valid(dump_valid1), .dump_ready(1'b1),
        .dump_addr(dump_addr1), .dump_data(dump_data1), .dump_csum(dump_csum1),
        .busy(busy1), .done(done1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a);
        if (a == 10) return 32'd10;
        if (a == 30) return 32'h0000FFFF;
        return 32'd0;
    endfunction

    task automatic push_all();
        word_t w;
        for (int i = 0; i < 32; i++) begin
            w.a = 5'(i);
            w.d = exp_data(i);
            exp_q.push_back(w);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic wait_word(input int a);
        int k;
        for (k = 0; k < 200; k++) begin
            if (dump_valid && dump_addr == 5'(a)) break;
            cyc();
        end
        if (k == 200) begin
            n_cmp++; n_err++;
            $display("FAIL wait_word %0d: timeout, word never presented", a);
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            if (done) break;
            cyc();
        end
        if (k == 200) begin
            n_cmp++; n_err++;
            $display("FAIL wait_done: timeout, done never pulsed");
        end
    endtask

    // scoreboard monitor: every presented word is compared to the queue head,
    // so stalled words are re-checked each cycle; popped on transfer
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst && done) done_cnt++;
            if (!rst && dump_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected word: addr %0d data 0x%0h with empty queue", dump_addr, dump_data);
                end else begin
                    w = exp_q[0];
                    chk("word addr", 32'(dump_addr), 32'(w.a));
                    chk("word data", dump_data, w.d);
                    if (dump_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n, dsnap;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[10] = 32'd10;
        rf[30] = 32'h0000FFFF;

        // reset values
        #12;
        chk("rst valid", 32'(dump_valid), 0);
        chk("rst addr", 32'(dump_addr), 0);
        chk("rst data", dump_data, 0);
        chk("rst csum", dump_csum, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst readreg", 32'(rf_readreg), 0);
        chk("rst readreg one", 32'(rf_readreg1), 30);
        cyc(); rst = 1'b0; cyc();

        // 1: full dump at full rate
        push_all();
        pulse_start();
        chk("t1 busy after start", 32'(busy), 1);
        n = 0;
        for (int k = 0; k < 5 && !dump_valid; k++) cyc();
        while (dump_valid && n < 100) begin n++; cyc(); end
        chk("t1 consecutive words", 32'(n), 32);
        chk("t1 done after last", 32'(done), 1);
        chk("t1 busy with done", 32'(busy), 0);
`ifdef REGDUMP_CHECKSUM_EN
        chk("t1 csum", dump_csum, 32'h00010009);
`else
        chk("t1 csum", dump_csum, 32'h0);
`endif
        chk("t1 queue drained", 32'(exp_q.size()), 0);
        cyc();
        chk("t1 done one cycle", 32'(done), 0);
        chk("t1 done count", 32'(done_cnt), 1);

        // 2: stall 5 cycles on word 3
        push_all();
        pulse_start();
        wait_word(3);
        dump_ready = 1'b0;
        repeat (5) cyc();
        chk("t2 still addr3", 32'(dump_addr), 3);
        dump_ready = 1'b1;
        wait_done();
        chk("t2 queue drained", 32'(exp_q.size()), 0);
        cyc();

        // 3: abort on word 7, then restart from 0
        push_all();
        pulse_start();
        wait_word(7);
        dump_ready = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t3 valid after abort", 32'(dump_valid), 0);
        chk("t3 busy after abort", 32'(busy), 0);
        chk("t3 readreg rewound", 32'(rf_readreg), 0);
        exp_q.delete();
        dsnap = done_cnt;
        repeat (3) cyc();
        chk("t3 no done on abort", 32'(done_cnt), 32'(dsnap));
        dump_ready = 1'b1;
        push_all();
        pulse_start();
        wait_done();
        chk("t3 restart drained", 32'(exp_q.size()), 0);
        cyc();

        // 4: start mid-dump ignored; rst at word 12
        push_all();
        pulse_start();
        wait_word(5);
        pulse_start();
        wait_word(12);
        rst = 1'b1;
        #1;
        chk("t4 rst valid", 32'(dump_valid), 0);
        chk("t4 rst addr", 32'(dump_addr), 0);
        chk("t4 rst data", dump_data, 0);
        chk("t4 rst busy", 32'(busy), 0);
        chk("t4 rst done", 32'(done), 0);
        chk("t4 rst readreg", 32'(rf_readreg), 0);
        chk("t4 rst csum", dump_csum, 0);
        chk("t4 words before rst", 32'(exp_q.size()), 20);
        exp_q.delete();
        cyc(); rst = 1'b0; cyc();

        // 5: single-register dump (FIRST_REG == LAST_REG == 30)
        start1 = 1'b1; cyc(); start1 = 1'b0;
        n = 0;
        for (int k = 0; k < 10 && !dump_valid1; k++) cyc();
        chk("t5 valid", 32'(dump_valid1), 1);
        chk("t5 addr", 32'(dump_addr1), 30);
        chk("t5 data", dump_data1, 32'h0000FFFF);
        cyc();
        chk("t5 valid dropped", 32'(dump_valid1), 0);
        chk("t5 done", 32'(done1), 1);
`ifdef REGDUMP_CHECKSUM_EN
        chk("t5 csum", dump_csum1, 32'h0000FFFF);
`else
        chk("t5 csum", dump_csum1, 32'h0);
`endif
        cyc();
        chk("t5 done cleared", 32'(done1), 0);
        chk("main idle", 32'(dump_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
